// File: rtl/scheduler_pkg.sv
// Shared types and default widths for the MemorEDF scheduler family.
// The EDF_MISS_COUNT_EN macro (used by edf_scheduler) adds per-queue deadline-miss counters.
package scheduler_pkg;

  localparam int DEFAULT_NUMBER_OF_QUEUES  = 4;
  localparam int DEFAULT_REGISTER_SIZE     = 32;
  localparam int DEFAULT_MISS_COUNTER_SIZE = 16;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    OFFER = 2'd2
  } state_t;

  typedef logic [DEFAULT_REGISTER_SIZE-1:0] deadline_t;

endpackage

// File: rtl/edf_min_finder.sv
// Combinational argmin over masked deadlines; ties go to the lowest index.
// Shared by the EDF scheduler and later fixed-priority / hybrid variants.
module edf_min_finder #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  localparam int INDEX_WIDTH     = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] deadlines,
  input  logic [NUMBER_OF_QUEUES-1:0]               mask,
  output logic                                      found,
  output logic [INDEX_WIDTH-1:0]                    index
);

  logic [REGISTER_SIZE-1:0] deadline_w [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] best_value;

  generate
    for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_unpack
      assign deadline_w[gi] = deadlines[gi*REGISTER_SIZE +: REGISTER_SIZE];
    end
  endgenerate

  // Strict less-than keeps the earliest index on equal deadlines.
  always_comb begin
    found      = 1'b0;
    index      = '0;
    best_value = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (mask[i] && (!found || deadline_w[i] < best_value)) begin
        found      = 1'b1;
        index      = INDEX_WIDTH'(i);
        best_value = deadline_w[i];
      end
    end
  end

endmodule

// File: rtl/edf_scheduler.sv
// Earliest-Deadline-First arbiter offering the most urgent non-empty queue over valid/ready.
// Define EDF_MISS_COUNT_EN to add the per-queue deadline-miss counters on the misses port.
module edf_scheduler
  import scheduler_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES  = DEFAULT_NUMBER_OF_QUEUES,
  parameter int REGISTER_SIZE     = DEFAULT_REGISTER_SIZE,
  parameter int MISS_COUNTER_SIZE = DEFAULT_MISS_COUNTER_SIZE,
  localparam int SEL_WIDTH        = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0]     period,
  input  logic [NUMBER_OF_QUEUES-1:0]                   empty,
  input  logic                                          ready,
  output logic                                          valid,
`ifdef EDF_MISS_COUNT_EN
  output logic [NUMBER_OF_QUEUES*MISS_COUNTER_SIZE-1:0] misses,
`endif
  output logic [SEL_WIDTH-1:0]                          selection
);

  generate
    if (NUMBER_OF_QUEUES < 2 || REGISTER_SIZE < 1 || MISS_COUNTER_SIZE < 1) begin : g_bad_param
      $error("edf_scheduler: unsupported parameter combination");
    end
  endgenerate

  state_t                       state_reg;
  logic                         valid_reg;
  logic [SEL_WIDTH-1:0]         selection_reg;
  logic [REGISTER_SIZE-1:0]     d_reg      [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0]     d_next     [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0]     period_w   [NUMBER_OF_QUEUES];
  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] d_flat;
  logic                         min_found;
  logic [SEL_WIDTH-1:0]         min_index;
  logic                         grant;

  assign grant = (state_reg == OFFER) && valid_reg && ready;

  generate
    for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_queue
      assign period_w[gi] = period[gi*REGISTER_SIZE +: REGISTER_SIZE];
      assign d_flat[gi*REGISTER_SIZE +: REGISTER_SIZE] = d_reg[gi];
      assign d_next[gi] = (d_reg[gi] == '0) ? '0 : d_reg[gi] - REGISTER_SIZE'(1);
    end
  endgenerate

  edf_min_finder #(
    .NUMBER_OF_QUEUES (NUMBER_OF_QUEUES),
    .REGISTER_SIZE    (REGISTER_SIZE)
  ) u_min_finder (
    .deadlines (d_flat),
    .mask      (~empty),
    .found     (min_found),
    .index     (min_index)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= INIT;
      valid_reg     <= 1'b0;
      selection_reg <= '0;
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) d_reg[i] <= '0;
    end else begin
      case (state_reg)
        INIT: begin
          for (int i = 0; i < NUMBER_OF_QUEUES; i++) d_reg[i] <= period_w[i];
          state_reg <= IDLE;
        end
        IDLE: begin
          for (int i = 0; i < NUMBER_OF_QUEUES; i++) d_reg[i] <= d_next[i];
          if (min_found) begin
            selection_reg <= min_index;
            valid_reg     <= 1'b1;
            state_reg     <= OFFER;
          end
        end
        OFFER: begin
          for (int i = 0; i < NUMBER_OF_QUEUES; i++) d_reg[i] <= d_next[i];
          // Grant beats withdrawal; the reload overrides the decrement above.
          if (ready) begin
            d_reg[selection_reg] <= period_w[selection_reg];
            valid_reg            <= 1'b0;
            state_reg            <= IDLE;
          end else if (empty[selection_reg]) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= INIT;
        end
      endcase
    end
  end

  assign valid     = valid_reg;
  assign selection = selection_reg;

`ifdef EDF_MISS_COUNT_EN
  logic [MISS_COUNTER_SIZE-1:0] misses_reg [NUMBER_OF_QUEUES];

  generate
    for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_miss
      // A miss is a pending queue whose deadline expires without being granted.
      logic miss_event;
      assign miss_event = (state_reg != INIT) && (d_reg[gi] == REGISTER_SIZE'(1)) && !empty[gi]
                          && !(grant && (selection_reg == SEL_WIDTH'(gi)));

      always_ff @(posedge clock) begin
        if (reset) begin
          misses_reg[gi] <= '0;
        end else if (miss_event && (misses_reg[gi] != '1)) begin
          misses_reg[gi] <= misses_reg[gi] + MISS_COUNTER_SIZE'(1);
        end
      end

      assign misses[gi*MISS_COUNTER_SIZE +: MISS_COUNTER_SIZE] = misses_reg[gi];
    end
  endgenerate
`endif

endmodule
